// File: rtl/cache_definition.sv
// Shared cache-side types: sequencer FSM states, ROM entry layout,
// and a saturating-increment helper for the sequencer counters.
package cache_definition;

  localparam int CD_ADDR_W = 20;
  localparam int CD_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic                 last;
    logic                 rw;
    logic [CD_ADDR_W-1:0] addr;
    logic [CD_DATA_W-1:0] data;
  } rom_entry_t;

  // Increments v, holding at 2^w-1 (w <= 32).
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF
                    : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cache_req_sequencer.sv
// Replays a ROM table of CPU requests into the cache CPU port and
// self-checks read data against the stored expected value.
//
// Ports:
//   clk, rst (async, active-low)
//   start, loop_en, pause          run control
//   rom_addr / rom_dout            ROM read port (entry = last|rw|addr|data)
//   req_valid/rw/addr/data         cache request
//   rsp_stopped / rsp_data         cache stall and read data
//   busy, done                     run status
//   pass_count, err_count          saturating counters
//   first_err_idx, err_flag        first mismatch capture
// DEPTH must be a power of two and at least 2; CNT_W at most 32.
module cache_req_sequencer
  import cache_definition::*;
#(
  parameter  int ADDR_W = 20,
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 1024,
  parameter  int CNT_W  = 16,
  localparam int ROM_W  = 2 + ADDR_W + DATA_W,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop_en,
  input  logic              pause,
  output logic [IW-1:0]     rom_addr,
  input  logic [ROM_W-1:0]  rom_dout,
  output logic              req_valid,
  output logic              req_rw,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  input  logic              rsp_stopped,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [IW-1:0]     first_err_idx,
  output logic              err_flag
);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [IW-1:0]     r_rom_addr;
  logic [IW-1:0]     r_idx;
  logic              r_last;
  logic              r_req_rw;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_data;
  logic              r_done;
  logic [CNT_W-1:0]  r_pass;
  logic [CNT_W-1:0]  r_err;
  logic [IW-1:0]     r_first_idx;
  logic              r_err_flag;

  logic              w_ent_last;
  logic              w_ent_rw;
  logic [ADDR_W-1:0] w_ent_addr;
  logic [DATA_W-1:0] w_ent_data;
  logic              w_valid;
  logic              w_busy;
  logic              w_accept;
  logic              w_last;
  logic              w_start;
  logic              w_mismatch;
  logic              w_load;

  assign w_ent_last = rom_dout[ROM_W-1];
  assign w_ent_rw   = rom_dout[ROM_W-2];
  assign w_ent_addr = rom_dout[DATA_W +: ADDR_W];
  assign w_ent_data = rom_dout[DATA_W-1:0];

  assign w_accept = w_valid & ~rsp_stopped;

  // The final ROM slot always ends a pass, marked or not.
  assign w_last = r_last
                | (r_idx == IW'(DEPTH - 1));

  assign w_start = start
                 & ((r_state == S_IDLE)
                 |  (r_state == S_DONE));

  // req_data holds the expected value for reads.
  assign w_mismatch = w_accept & ~r_req_rw
                    & (rsp_data != r_req_data);

  // Entry load: the FETCH cycle, or back-to-back after a non-last accept.
  assign w_load = (r_state == S_FETCH)
                | (w_accept & ~w_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_accept && w_last) begin
          w_state_nxt = loop_en ? S_FETCH : S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_valid = 1'b0;
    w_busy  = 1'b0;
    unique case (r_state)
      S_FETCH: w_busy = 1'b1;
      S_ISSUE: begin
        w_busy  = 1'b1;
        w_valid = ~pause;
      end
      S_IDLE, S_DONE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rom_addr  <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_req_rw    <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_done      <= 1'b0;
      r_pass      <= '0;
      r_err       <= '0;
      r_first_idx <= '0;
      r_err_flag  <= 1'b0;
    end else if (w_start) begin
      r_rom_addr  <= '0;
      r_done      <= 1'b0;
      r_pass      <= '0;
      r_err       <= '0;
      r_first_idx <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      if (w_mismatch) begin
        r_err <= CNT_W'(sat_inc(32'(r_err), CNT_W));
        if (!r_err_flag) begin
          r_err_flag  <= 1'b1;
          r_first_idx <= r_idx;
        end
      end
      if (w_load) begin
        r_req_rw   <= w_ent_rw;
        r_req_addr <= w_ent_addr;
        r_req_data <= w_ent_data;
        r_last     <= w_ent_last;
        r_idx      <= r_rom_addr;
        r_rom_addr <= r_rom_addr + IW'(1);
      end else if (w_accept) begin
        r_pass <= CNT_W'(sat_inc(32'(r_pass), CNT_W));
        if (loop_en) begin
          r_rom_addr <= '0;
        end else begin
          r_done <= 1'b1;
        end
      end
    end
  end

  assign rom_addr      = r_rom_addr;
  assign req_valid     = w_valid;
  assign req_rw        = r_req_rw;
  assign req_addr      = r_req_addr;
  assign req_data      = r_req_data;
  assign busy          = w_busy;
  assign done          = r_done;
  assign pass_count    = r_pass;
  assign err_count     = r_err;
  assign first_err_idx = r_first_idx;
  assign err_flag      = r_err_flag;

endmodule
